// File: rtl/npu_ahb_slave_mux.sv
// npu_ahb_slave_mux: AHB-Lite slave that decodes one port into a RW CSR bank, a RO status bank
// and NUM_MEM sync-read SRAM banks. Every accepted transfer takes exactly one wait state.
// Optional build macro NPU_AHB_ERR_RESP_EN: unmapped regions answer with a two-cycle ERROR
// response instead of the silent OKAY path.
module npu_ahb_slave_mux #(
   parameter int NUM_MEM = 2,
   parameter int MEM_AW  = 12,
   parameter int MEM_DW  = 8,
   parameter int NUM_RW  = 2,
   parameter int RW_W    = 4,
   parameter int NUM_RO  = 8,
   parameter int RGN_LSB = 12
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        hsel_i,
   input  logic [31:0]                 haddr_i,
   input  logic                        hwrite_i,
   input  logic [1:0]                  htrans_i,
   input  logic [2:0]                  hsize_i,
   input  logic [31:0]                 hwdata_i,
   input  logic                        hready_i,
   output logic                        hready_o,
   output logic                        hresp_o,
   output logic [31:0]                 hrdata_o,
   output logic [NUM_RW*RW_W-1:0]      rw_csr_o,
   input  logic [NUM_RO*32-1:0]        ro_status_i,
   output logic [NUM_MEM*MEM_AW-1:0]   mem_addr_o,
   output logic [NUM_MEM-1:0]          mem_wr_o,
   output logic [MEM_DW-1:0]           mem_wrdata_o,
   input  logic [NUM_MEM*MEM_DW-1:0]   mem_rddata_i
);

   // Offset must cover the CSR/RO word index bits [5:2] even for tiny memory banks.
   localparam int OFF_W = (MEM_AW > 6) ? MEM_AW : 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         w_rgn;
   logic               w_mapped;
   logic               w_accept;
   logic               w_in_wait;
   logic               w_csr_we;
   logic               w_rd_cap;
   logic [2:0]         r_rgn_l;
   logic [OFF_W-1:0]   r_off_l;
   logic               r_wr_l;
   logic               r_map_l;
   logic               r_hready;
   logic               r_hresp;
   logic [31:0]        r_hrdata;
   logic [31:0]        w_rd_word;
   logic [NUM_MEM-1:0] r_mem_wr;
   logic [NUM_MEM-1:0] w_mem_wr_nxt;
   logic [RW_W-1:0]    r_csr [NUM_RW];
   logic               w_unused_bits;

   assign w_rgn     = haddr_i[RGN_LSB+2:RGN_LSB];
   assign w_mapped  = ({29'd0, w_rgn} < 32'(NUM_MEM + 2));
   assign w_accept  = (r_state == ST_IDLE) && hsel_i && hready_i && htrans_i[1];
   assign w_in_wait = (r_state == ST_WAIT);
   assign w_csr_we  = w_in_wait && r_wr_l && r_map_l && (r_rgn_l == 3'd0);
   assign w_rd_cap  = w_in_wait && !r_wr_l;

   // Address bits above the decoded fields, size and unused data bits carry no meaning here.
   assign w_unused_bits = ^{hsize_i, haddr_i, hwdata_i, htrans_i};

   assign hready_o     = r_hready;
   assign hresp_o      = r_hresp;
   assign hrdata_o     = r_hrdata;
   assign mem_wr_o     = r_mem_wr;
   assign mem_wrdata_o = hwdata_i[MEM_DW-1:0];

   // Banks see the latched offset while a write is in its wait cycle, otherwise the live address
   // so a read's SRAM access starts in the address phase.
   for (genvar b = 0; b < NUM_MEM; b++) begin : g_bank
      assign mem_addr_o[b*MEM_AW +: MEM_AW] = (w_in_wait && r_wr_l) ? r_off_l[MEM_AW-1:0]
                                                                     : haddr_i[MEM_AW-1:0];
   end

   for (genvar k = 0; k < NUM_RW; k++) begin : g_csr_out
      assign rw_csr_o[k*RW_W +: RW_W] = r_csr[k];
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: one wait state per accepted transfer, optional two-cycle error path.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef NPU_AHB_ERR_RESP_EN
               w_state_nxt = w_mapped ? ST_WAIT : ST_ERR1;
`else
               w_state_nxt = ST_WAIT;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: w_state_nxt = ST_IDLE;
         ST_ERR1: w_state_nxt = ST_ERR2;
         ST_ERR2: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-bank write strobe for the coming wait cycle, decided at accept time.
   always_comb begin
      w_mem_wr_nxt = {NUM_MEM{1'b0}};
      for (int b = 0; b < NUM_MEM; b++) begin
         w_mem_wr_nxt[b] = w_accept && w_mapped && hwrite_i && (w_rgn == 3'(b + 2));
      end
   end

   // Read mux over CSR, RO status and memory banks; anything out of range reads zero.
   always_comb begin
      w_rd_word = 32'd0;
      if (r_rgn_l == 3'd0) begin
         for (int k = 0; k < NUM_RW; k++) begin
            w_rd_word = (r_off_l[4:2] == 3'(k)) ? 32'(r_csr[k]) : w_rd_word;
         end
      end else if (r_rgn_l == 3'd1) begin
         for (int k = 0; k < NUM_RO; k++) begin
            w_rd_word = (r_off_l[5:2] == 4'(k)) ? ro_status_i[k*32 +: 32] : w_rd_word;
         end
      end else begin
         for (int b = 0; b < NUM_MEM; b++) begin
            w_rd_word = (r_rgn_l == 3'(b + 2)) ? 32'(mem_rddata_i[b*MEM_DW +: MEM_DW]) : w_rd_word;
         end
      end
   end

   // Capture the address-phase control of an accepted transfer for use in its data phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgn_l <= 3'd0;
         r_off_l <= {OFF_W{1'b0}};
         r_wr_l  <= 1'b0;
         r_map_l <= 1'b0;
      end else if (w_accept) begin
         r_rgn_l <= w_rgn;
         r_off_l <= haddr_i[OFF_W-1:0];
         r_wr_l  <= hwrite_i;
         r_map_l <= w_mapped;
      end else begin
         r_rgn_l <= r_rgn_l;
         r_off_l <= r_off_l;
         r_wr_l  <= r_wr_l;
         r_map_l <= r_map_l;
      end
   end

   // Registered bus response and memory strobes, derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hready <= 1'b1;
         r_hresp  <= 1'b0;
         r_mem_wr <= {NUM_MEM{1'b0}};
      end else begin
         r_hready <= !((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ERR1));
         r_hresp  <= (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
         r_mem_wr <= w_mem_wr_nxt;
      end
   end

   // CSR bank: written in the wait cycle; CSR0 is a one-cycle pulse where a write beats the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_RW; k++) begin
            r_csr[k] <= {RW_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (w_csr_we && (r_off_l[4:2] == 3'(k))) begin
               r_csr[k] <= hwdata_i[RW_W-1:0];
            end else if (k == 0) begin
               r_csr[k] <= {RW_W{1'b0}};
            end else begin
               r_csr[k] <= r_csr[k];
            end
         end
      end
   end

   // Read data register: loaded at the end of a read's wait cycle, held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hrdata <= 32'd0;
      end else if (w_rd_cap) begin
         r_hrdata <= r_map_l ? w_rd_word : 32'd0;
      end else begin
         r_hrdata <= r_hrdata;
      end
   end

endmodule

// File: tb/tb_npu_ahb_slave_mux.sv
// Bench for npu_ahb_slave_mux: directed scenarios plus randomized transfers against a
// region-level reference model (CSR array, memory arrays, expected read register).
module tb_npu_ahb_slave_mux;
   localparam int NUM_MEM = 2;
   localparam int MEM_AW  = 12;
   localparam int MEM_DW  = 8;
   localparam int NUM_RW  = 2;
   localparam int RW_W    = 4;
   localparam int NUM_RO  = 8;
   localparam int RGN_LSB = 12;
   localparam int DEPTH   = 1 << MEM_AW;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        hsel_i;
   logic [31:0]                 haddr_i;
   logic                        hwrite_i;
   logic [1:0]                  htrans_i;
   logic [2:0]                  hsize_i;
   logic [31:0]                 hwdata_i;
   logic                        hready_i;
   logic                        hready_o;
   logic                        hresp_o;
   logic [31:0]                 hrdata_o;
   logic [NUM_RW*RW_W-1:0]      rw_csr_o;
   logic [NUM_RO*32-1:0]        ro_status_i;
   logic [NUM_MEM*MEM_AW-1:0]   mem_addr_o;
   logic [NUM_MEM-1:0]          mem_wr_o;
   logic [MEM_DW-1:0]           mem_wrdata_o;
   logic [NUM_MEM*MEM_DW-1:0]   mem_rddata_i;

   int total = 0;
   int bad   = 0;

   // Environment SRAM banks and the reference model state.
   logic [MEM_DW-1:0] sram  [NUM_MEM][DEPTH];
   logic [MEM_DW-1:0] m_mem [NUM_MEM][DEPTH];
   logic [RW_W-1:0]   m_csr [NUM_RW];
   logic [31:0]       m_rdata;
   logic              sram_init;

   npu_ahb_slave_mux #(
      .NUM_MEM(NUM_MEM), .MEM_AW(MEM_AW), .MEM_DW(MEM_DW), .NUM_RW(NUM_RW),
      .RW_W(RW_W), .NUM_RO(NUM_RO), .RGN_LSB(RGN_LSB)
   ) dut (
      .clk(clk), .reset(reset), .hsel_i(hsel_i), .haddr_i(haddr_i), .hwrite_i(hwrite_i),
      .htrans_i(htrans_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i), .hready_i(hready_i),
      .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o), .rw_csr_o(rw_csr_o),
      .ro_status_i(ro_status_i), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
      .mem_wrdata_o(mem_wrdata_o), .mem_rddata_i(mem_rddata_i)
   );

   always #5 clk = ~clk;

   function automatic logic [MEM_DW-1:0] pat(input int b, input int a);
      return MEM_DW'(a * 13 + b * 101 + 1);
   endfunction

   function automatic logic [NUM_RW*RW_W-1:0] csr_pack();
      logic [NUM_RW*RW_W-1:0] v;
      for (int k = 0; k < NUM_RW; k++) v[k*RW_W +: RW_W] = m_csr[k];
      return v;
   endfunction

   // Sync-read SRAM banks with one-cycle latency.
   always @(posedge clk) begin
      for (int b = 0; b < NUM_MEM; b++) begin
         if (sram_init) begin
            for (int a = 0; a < DEPTH; a++) sram[b][a] <= pat(b, a);
         end else begin
            if (mem_wr_o[b]) sram[b][mem_addr_o[b*MEM_AW +: MEM_AW]] <= mem_wrdata_o;
            mem_rddata_i[b*MEM_DW +: MEM_DW] <= sram[b][mem_addr_o[b*MEM_AW +: MEM_AW]];
         end
      end
   end

   task automatic bus_idle();
      hsel_i = 1'b0; htrans_i = 2'b00; hwrite_i = 1'b0; hready_i = 1'b1;
   endtask

   // One complete transfer (address, wait, completion) with checks in every cycle.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input string nm);
      int rgn, off, kc, kr;
      logic [NUM_MEM-1:0] exp_wr;
      logic [31:0] exp_rd;
      rgn = int'((addr >> RGN_LSB) & 32'd7);
      off = int'(addr & 32'(DEPTH - 1));
      kc  = (off >> 2) & 7;
      kr  = (off >> 2) & 15;
      exp_wr = '0;
      if (wr && rgn >= 2 && rgn < NUM_MEM + 2) exp_wr[rgn-2] = 1'b1;
      // address phase
      @(posedge clk); #1;
      hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = addr; hwrite_i = wr; hsize_i = 3'($urandom);
      @(negedge clk);
      total++; if (hready_o !== 1'b1) begin bad++; $display("FAIL %s A-hready got %b want 1", nm, hready_o); end
      // wait cycle: scramble address/direction to prove the latched values are used
      @(posedge clk); #1;
      hsel_i = 1'b0; htrans_i = 2'b00; haddr_i = $urandom; hwrite_i = 1'($urandom); hwdata_i = wdata;
      @(negedge clk);
      total++; if (hready_o !== 1'b0) begin bad++; $display("FAIL %s D1-hready got %b want 0", nm, hready_o); end
      total++; if (mem_wr_o !== exp_wr) begin bad++; $display("FAIL %s D1-mem_wr got %b want %b", nm, mem_wr_o, exp_wr); end
      if (exp_wr != '0) begin
         total++;
         if (mem_addr_o[(rgn-2)*MEM_AW +: MEM_AW] !== MEM_AW'(off) || mem_wrdata_o !== wdata[MEM_DW-1:0]) begin
            bad++; $display("FAIL %s D1-mem_addr/data got %h/%h want %h/%h", nm,
                            mem_addr_o[(rgn-2)*MEM_AW +: MEM_AW], mem_wrdata_o, MEM_AW'(off), wdata[MEM_DW-1:0]);
         end
      end
      // model effect at end of the wait cycle
      if (wr) begin
         if (rgn == 0 && kc < NUM_RW) m_csr[kc] = wdata[RW_W-1:0];
         else if (rgn >= 2 && rgn < NUM_MEM + 2) m_mem[rgn-2][off] = wdata[MEM_DW-1:0];
      end else begin
         exp_rd = 32'd0;
         if (rgn == 0 && kc < NUM_RW) exp_rd = 32'(m_csr[kc]);
         else if (rgn == 1 && kr < NUM_RO) exp_rd = ro_status_i[kr*32 +: 32];
         else if (rgn >= 2 && rgn < NUM_MEM + 2) exp_rd = 32'(m_mem[rgn-2][off]);
         m_rdata = exp_rd;
      end
      // completion cycle
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (hready_o !== 1'b1 || hresp_o !== 1'b0) begin bad++; $display("FAIL %s D2-resp got %b/%b want 1/0", nm, hready_o, hresp_o); end
      total++; if (hrdata_o !== m_rdata) begin bad++; $display("FAIL %s D2-hrdata got %h want %h", nm, hrdata_o, m_rdata); end
      total++; if (rw_csr_o !== csr_pack()) begin bad++; $display("FAIL %s D2-rw_csr got %h want %h", nm, rw_csr_o, csr_pack()); end
      m_csr[0] = '0;
   endtask

   // Idle/BUSY cycles with random select: nothing may be accepted.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         hsel_i = 1'($urandom); htrans_i = 2'($urandom_range(0, 1)); hwrite_i = 1'($urandom); haddr_i = $urandom;
         @(negedge clk);
         total++; if (hready_o !== 1'b1 || mem_wr_o !== '0) begin bad++; $display("FAIL idle hready/mem_wr got %b/%b want 1/0", hready_o, mem_wr_o); end
      end
      @(posedge clk); #1; bus_idle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; bus_idle(); haddr_i = 32'd0; hwdata_i = 32'd0; hsize_i = 3'd2;
      ro_status_i = '0; sram_init = 1'b1;
      for (int b = 0; b < NUM_MEM; b++) for (int a = 0; a < DEPTH; a++) m_mem[b][a] = pat(b, a);
      for (int k = 0; k < NUM_RW; k++) m_csr[k] = '0;
      m_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1; sram_init = 1'b0;
      @(negedge clk);
      total++; if (hready_o !== 1'b1 || hresp_o !== 1'b0) begin bad++; $display("FAIL reset-resp got %b/%b want 1/0", hready_o, hresp_o); end
      total++; if (hrdata_o !== 32'd0 || rw_csr_o !== '0 || mem_wr_o !== '0) begin bad++; $display("FAIL reset-outs got %h/%h/%b want 0", hrdata_o, rw_csr_o, mem_wr_o); end
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      total++; if (hready_o !== 1'b1 || hrdata_o !== 32'd0) begin bad++; $display("FAIL post-reset got %b/%h want 1/0", hready_o, hrdata_o); end
   endtask

   task automatic test_mem_basic();
      xfer(1'b1, 32'h0000_2123, 32'h0000_00A5, "mem_wr_b0");
      xfer(1'b0, 32'h0000_2123, 32'h0, "mem_rd_b0");
      total++; if (hrdata_o !== 32'h0000_00A5) begin bad++; $display("FAIL mem_rd_a5 got %h want 000000a5", hrdata_o); end
      xfer(1'b0, 32'h0000_3123, 32'h0, "mem_rd_b1_untouched");
      xfer(1'b1, 32'h0000_3FFF, 32'h1234_56C3, "mem_wr_b1_top");
      xfer(1'b0, 32'h0000_3FFF, 32'h0, "mem_rd_b1_top");
   endtask

   task automatic test_csr();
      xfer(1'b1, 32'h0000_0000, 32'h1, "csr0_set");
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (rw_csr_o[RW_W-1:0] !== '0) begin bad++; $display("FAIL csr0_selfclear got %h want 0", rw_csr_o[RW_W-1:0]); end
      xfer(1'b1, 32'h0000_0004, 32'h9, "csr1_wr");
      idle_cycles(3);
      total++; if (rw_csr_o[2*RW_W-1:RW_W] !== 4'h9) begin bad++; $display("FAIL csr1_hold got %h want 9", rw_csr_o[2*RW_W-1:RW_W]); end
      xfer(1'b0, 32'h0000_0004, 32'h0, "csr1_rd");
      xfer(1'b0, 32'h0000_0000, 32'h0, "csr0_rd");
      xfer(1'b1, 32'h0000_0014, 32'hF, "csr5_drop");
      xfer(1'b0, 32'h0000_0014, 32'h0, "csr5_rd");
   endtask

   task automatic test_ro();
      for (int k = 0; k < NUM_RO; k++) ro_status_i[k*32 +: 32] = $urandom;
      ro_status_i[3*32 +: 32] = 32'hDEAD_BEEF;
      xfer(1'b0, 32'h0000_100C, 32'h0, "ro_w3");
      total++; if (hrdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ro_deadbeef got %h want deadbeef", hrdata_o); end
      xfer(1'b0, 32'h0000_103C, 32'h0, "ro_w15_zero");
      xfer(1'b1, 32'h0000_1008, 32'h5555_5555, "ro_wr_noeffect");
      xfer(1'b0, 32'h0000_1008, 32'h0, "ro_w2");
   endtask

   task automatic test_ignored();
      @(posedge clk); #1;
      hsel_i = 1'b1; htrans_i = 2'b01; hwrite_i = 1'b1; haddr_i = 32'h0000_2010;
      @(posedge clk); #1;
      htrans_i = 2'b10; hready_i = 1'b0;
      @(negedge clk);
      total++; if (hready_o !== 1'b1 || mem_wr_o !== '0) begin bad++; $display("FAIL busy_ignored got %b/%b want 1/0", hready_o, mem_wr_o); end
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      total++; if (hready_o !== 1'b1 || mem_wr_o !== '0) begin bad++; $display("FAIL hready_i_low_ignored got %b/%b want 1/0", hready_o, mem_wr_o); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] seen;
      int off;
      off = 12'h2A4;
      seen = '0;
      // bank1 write address phase
      @(posedge clk); #1;
      hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b1; haddr_i = 32'h0000_32A4;
      @(negedge clk); seen[4] = hready_o;
      // write wait cycle, next address already presented and held
      @(posedge clk); #1;
      hwdata_i = {24'd0, ~pat(1, off)}; hwrite_i = 1'b0; haddr_i = 32'h0000_22A4;
      @(negedge clk); seen[3] = hready_o;
      total++; if (mem_wr_o !== 2'b10) begin bad++; $display("FAIL b2b_wr_strobe got %b want 10", mem_wr_o); end
      m_mem[1][off] = ~pat(1, off);
      // write completes, bank0 read accepted
      @(posedge clk); #1;
      @(negedge clk); seen[2] = hready_o;
      total++; if (mem_wr_o !== 2'b00) begin bad++; $display("FAIL b2b_d2_strobe got %b want 00", mem_wr_o); end
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk); seen[1] = hready_o;
      total++; if (mem_wr_o !== 2'b00) begin bad++; $display("FAIL b2b_rd_strobe got %b want 00", mem_wr_o); end
      m_rdata = 32'(m_mem[0][off]);
      @(posedge clk); #1;
      @(negedge clk); seen[0] = hready_o;
      total++; if (seen !== 5'b10101) begin bad++; $display("FAIL b2b_hready_pattern got %b want 10101", seen); end
      total++; if (hrdata_o !== m_rdata) begin bad++; $display("FAIL b2b_rd_b0 got %h want %h", hrdata_o, m_rdata); end
      xfer(1'b0, 32'h0000_32A4, 32'h0, "b2b_rd_b1");
   endtask

   task automatic test_unmapped();
      xfer(1'b0, 32'h0000_2010, 32'h0, "pre_unmapped_rd");
`ifdef NPU_AHB_ERR_RESP_EN
      begin
         logic [31:0] held;
         held = m_rdata;
         @(posedge clk); #1;
         hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b0; haddr_i = 32'h0000_7010;
         @(negedge clk);
         total++; if (hready_o !== 1'b1 || hresp_o !== 1'b0) begin bad++; $display("FAIL err_A got %b/%b want 1/0", hready_o, hresp_o); end
         @(posedge clk); #1; bus_idle();
         @(negedge clk);
         total++; if (hready_o !== 1'b0 || hresp_o !== 1'b1) begin bad++; $display("FAIL err_1 got %b/%b want 0/1", hready_o, hresp_o); end
         @(posedge clk); #1;
         @(negedge clk);
         total++; if (hready_o !== 1'b1 || hresp_o !== 1'b1) begin bad++; $display("FAIL err_2 got %b/%b want 1/1", hready_o, hresp_o); end
         total++; if (hrdata_o !== held) begin bad++; $display("FAIL err_hrdata got %h want %h", hrdata_o, held); end
         @(posedge clk); #1;
         @(negedge clk);
         total++; if (hready_o !== 1'b1 || hresp_o !== 1'b0) begin bad++; $display("FAIL err_done got %b/%b want 1/0", hready_o, hresp_o); end
      end
`else
      xfer(1'b1, 32'h0000_7010, 32'h0000_00FF, "unmapped7_wr");
      xfer(1'b0, 32'h0000_7010, 32'h0, "unmapped7_rd");
      xfer(1'b0, 32'h0000_4010, 32'h0, "unmapped4_rd");
      xfer(1'b0, 32'h0000_2010, 32'h0, "mem_after_unmapped");
`endif
   endtask

   task automatic test_random();
      int rgn, top;
      logic [31:0] addr;
`ifdef NPU_AHB_ERR_RESP_EN
      top = NUM_MEM + 1;
`else
      top = 7;
`endif
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < NUM_RO; k++) ro_status_i[k*32 +: 32] = $urandom;
         rgn  = $urandom_range(0, top);
         addr = ($urandom & 32'hFFFF_8000) | (32'(rgn) << RGN_LSB) | 32'($urandom_range(0, DEPTH - 1));
         xfer(1'($urandom), addr, $urandom, "random");
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
   endtask

   task automatic test_reset_mid();
      xfer(1'b1, 32'h0000_0004, 32'h6, "pre_reset_csr1");
      @(posedge clk); #1;
      hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b1; haddr_i = 32'h0000_2055;
      @(posedge clk); #1;
      bus_idle(); hwdata_i = 32'h0000_003C;
      @(negedge clk);
      total++; if (mem_wr_o !== 2'b01) begin bad++; $display("FAIL rst_mid_pre_strobe got %b want 01", mem_wr_o); end
      #1 reset = 1'b1;
      #1;
      total++; if (mem_wr_o !== '0 || hready_o !== 1'b1 || rw_csr_o !== '0) begin
         bad++; $display("FAIL rst_mid_outs got %b/%b/%h want 0/1/0", mem_wr_o, hready_o, rw_csr_o);
      end
      for (int k = 0; k < NUM_RW; k++) m_csr[k] = '0;
      m_rdata = 32'd0;
      @(posedge clk); #1; reset = 1'b0;
      xfer(1'b0, 32'h0000_2055, 32'h0, "rst_mid_no_write");
   endtask

   initial begin
      test_reset();
      test_mem_basic();
      test_csr();
      test_ro();
      test_ignored();
      test_back_to_back();
      test_unmapped();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
